// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// State encoding: bit0 = I-cache refill pending, bit1 = D-cache refill pending.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_I  = 2'b01,
    WAIT_D  = 2'b10,
    WAIT_ID = 2'b11
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         PERF_W   = 32;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/miss inputs and pipeline controls between the core and pipe_ctrl.
// master = pipeline side, slave = pipe_ctrl.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [4:0]        D_rs1_idx;
  logic [4:0]        D_rs2_idx;
  logic              D_use_rs1;
  logic              D_use_rs2;
  logic [4:0]        E_rd_idx;
  logic              E_is_load;
  logic              E_jb;
  logic              im_miss;
  logic              dm_miss;
  logic              im_done;
  logic              dm_done;

  logic              stall;
  logic              jb;
  logic              waiting;
  logic              pc_hold;
  logic              err;
  logic [PERF_W-1:0] cnt_stall;
  logic [PERF_W-1:0] cnt_wait;
  logic [PERF_W-1:0] cnt_flush;

  modport master (
    output D_rs1_idx, D_rs2_idx, D_use_rs1, D_use_rs2, E_rd_idx, E_is_load,
           E_jb, im_miss, dm_miss, im_done, dm_done,
    input  stall, jb, waiting, pc_hold, err, cnt_stall, cnt_wait, cnt_flush
  );

  modport slave (
    input  D_rs1_idx, D_rs2_idx, D_use_rs1, D_use_rs2, E_rd_idx, E_is_load,
           E_jb, im_miss, dm_miss, im_done, dm_done,
    output stall, jb, waiting, pc_hold, err, cnt_stall, cnt_wait, cnt_flush
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: counts cycles with en high, sticks at all-ones.
module pipe_perf_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int W = PERF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // count enabled cycles, holding at the maximum value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (en) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the RV32I cached core: load-use bubble, branch flush,
// cache-miss freeze with watchdog. Priority: waiting > jb > stall.
// Optional macro PIPE_CTRL_PERF_EN builds the stall/wait/flush counters;
// without it the counter outputs read 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MISS_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int                WCNT_W   = $clog2(MISS_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MISS_TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic              i_pend_nxt;
  logic              d_pend_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_cnt_nxt;
  logic              err_q;
  logic              hz;
  logic              waiting;
  logic              jb;
  logic              stall;

  function automatic logic [WCNT_W-1:0] sat_inc_wcnt(input logic [WCNT_W-1:0] v);
    return (v == WCNT_MAX) ? v : v + 1'b1;
  endfunction

  // next pending pair per cache; the state is that pair, misses on a pending
  // cache and dones on an idle cache fall out of the same rule
  always_comb begin
    i_pend_nxt   = (state[0] & ~bus.im_done) | bus.im_miss;
    d_pend_nxt   = (state[1] & ~bus.dm_done) | bus.dm_miss;
    state_nxt    = state_t'({d_pend_nxt, i_pend_nxt});
    wait_cnt_nxt = (state == RUN) ? '0 : sat_inc_wcnt(wait_cnt);
  end

  // miss-tracking FSM with watchdog; err sets on the edge the count reaches
  // the timeout and stays until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_q    <= err_q | (wait_cnt_nxt == WCNT_MAX);
    end
  end

  // zero-latency controls; a miss freezes the pipe in the cycle it is seen
  always_comb begin
    waiting = (state != RUN) | bus.im_miss | bus.dm_miss;
    jb      = bus.E_jb & ~waiting;
    hz      = bus.E_is_load & (bus.E_rd_idx != REG_ZERO) &
              ((bus.D_use_rs1 & (bus.D_rs1_idx == bus.E_rd_idx)) |
               (bus.D_use_rs2 & (bus.D_rs2_idx == bus.E_rd_idx)));
    stall   = hz & ~jb & ~waiting;
  end

  assign bus.waiting = waiting;
  assign bus.jb      = jb;
  assign bus.stall   = stall;
  assign bus.pc_hold = stall | waiting;
  assign bus.err     = err_q;

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt #(.W(PERF_W)) u_cnt_stall (
    .clk (clk), .rst (rst), .en (stall),   .cnt (bus.cnt_stall)
  );
  pipe_perf_cnt #(.W(PERF_W)) u_cnt_wait (
    .clk (clk), .rst (rst), .en (waiting), .cnt (bus.cnt_wait)
  );
  pipe_perf_cnt #(.W(PERF_W)) u_cnt_flush (
    .clk (clk), .rst (rst), .en (jb),      .cnt (bus.cnt_flush)
  );
`else
  assign bus.cnt_stall = '0;
  assign bus.cnt_wait  = '0;
  assign bus.cnt_flush = '0;
`endif

endmodule
